fetch_unit: RTL

Instruction fetch stage of the multicycle RISC-V core. It sits directly upstream of the main control decoder. It owns the PC, issues one instruction-memory request at a time, and holds the returned word in an output register. It presents `OPCODE`/`INSTR`/`PC_OUT` to decode with a valid/ready handshake, and accepts PC redirects from branch/jump resolution.

---
 rtl/fetch_unit_if.sv | 57 +++++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode handshake and redirect input.
interface fetch_unit_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;

    // instruction memory port
    logic              IMEM_REQ;
    logic [XLEN-1:0]   IMEM_ADDR;
    logic              IMEM_RVALID;
    logic [XLEN-1:0]   IMEM_RDATA;

    // decode-side handshake
    logic              VALID;
    logic              READY;
    logic [XLEN-1:0]   INSTR;
    logic [OPC_W-1:0]  OPCODE;
    logic [XLEN-1:0]   PC_OUT;

    // branch/jump resolution
    logic              REDIRECT;
    logic [XLEN-1:0]   REDIRECT_PC;

    // handed-over instruction count
    logic [XLEN-1:0]   FETCH_CNT;

    // fetch unit side
    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_RVALID,
        input  IMEM_RDATA,
        output VALID,
        input  READY,
        output INSTR,
        output OPCODE,
        output PC_OUT,
        input  REDIRECT,
        input  REDIRECT_PC,
        output FETCH_CNT
    );

    // memory / decode / resolution side
    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_RVALID,
        output IMEM_RDATA,
        input  VALID,
        output READY,
        input  INSTR,
        input  OPCODE,
        input  PC_OUT,
        output REDIRECT,
        output REDIRECT_PC,
        input  FETCH_CNT
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight,
// holds the returned word for decode and absorbs redirects by dropping stale data.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          CLK,
    input  logic          RST_N,
    fetch_unit_if.master  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_instr;
    logic [XLEN-1:0]   r_pc_out;
    logic [XLEN-1:0]   r_fetch_cnt;
    logic              r_imem_req;
    logic              r_valid;

    logic              w_imem_req_nxt;
    logic              w_valid_nxt;
    logic [XLEN-1:0]   w_redirect_tgt;
    logic [XLEN-1:0]   w_pc_inc;
    logic              w_rsp_take;
    logic              w_handshake;
    logic              w_unused_redirect_lsb;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign w_redirect_tgt        = {bus.REDIRECT_PC[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsb = ^bus.REDIRECT_PC[1:0];
    assign w_pc_inc              = r_pc + XLEN'(4);

    // A response is kept only in WAIT and only if no redirect races it.
    assign w_rsp_take  = (r_state == S_WAIT) && bus.IMEM_RVALID && !bus.REDIRECT;
    assign w_handshake = (r_state == S_HOLD) && bus.READY;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; redirects divert through DROP while a request is in flight.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                w_state_nxt = bus.REDIRECT ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (bus.IMEM_RVALID) begin
                    w_state_nxt = bus.REDIRECT ? S_REQ : S_HOLD;
                end else if (bus.REDIRECT) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                if (bus.REDIRECT || bus.READY) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (bus.IMEM_RVALID) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore output decode of the upcoming state, registered below.
    always_comb begin
        w_imem_req_nxt = 1'b0;
        w_valid_nxt    = 1'b0;
        case (w_state_nxt)
            S_REQ:   w_imem_req_nxt = 1'b1;
            S_HOLD:  w_valid_nxt    = 1'b1;
            default: begin
                w_imem_req_nxt = 1'b0;
                w_valid_nxt    = 1'b0;
            end
        endcase
    end

    // Output strobes registered so they track the state register exactly.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_imem_req <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_imem_req <= w_imem_req_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    // PC, instruction holding register and delivered-instruction counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc        <= RESET_PC;
            r_instr     <= NOP_INSTR;
            r_pc_out    <= RESET_PC;
            r_fetch_cnt <= '0;
        end else begin
            if (bus.REDIRECT) begin
                r_pc <= w_redirect_tgt;
            end else if (w_rsp_take) begin
                r_pc <= w_pc_inc;
            end
            if (w_rsp_take) begin
                r_instr  <= bus.IMEM_RDATA;
                r_pc_out <= r_pc;
            end
            if (w_handshake) begin
                r_fetch_cnt <= r_fetch_cnt + XLEN'(1);
            end
        end
    end

    assign bus.IMEM_REQ  = r_imem_req;
    assign bus.IMEM_ADDR = r_pc;
    assign bus.VALID     = r_valid;
    assign bus.INSTR     = r_instr;
    assign bus.OPCODE    = r_instr[OPC_W-1:0];
    assign bus.PC_OUT    = r_pc_out;
    assign bus.FETCH_CNT = r_fetch_cnt;

endmodule
